avalon_pio_ext: RTL and testbench

- Parametrised Avalon-MM slave general-purpose I/O port; successor to the fixed-width output-only LED/PIO registers in the Qsys system.
- Per-bit direction control, atomic bit set/clear, synchronised input sampling, edge capture and a maskable interrupt.
- Sits between the Nios II data master (via interconnect) and board pins (LEDs, switches, keys, GPIO headers).

---
 rtl/avalon_pio_ext.sv | 132 +++++++++++++
 tb/tb_avalon_pio_ext.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/avalon_pio_ext.sv
// avalon_pio_ext: Avalon-MM slave GPIO port with per-bit direction, atomic set/clear,
//   synchronised input sampling, edge capture and a maskable level interrupt.
// Latency: writes take effect on the edge they are sampled; readdata is zero-latency
//   combinational. Inputs are visible 2 edges after they settle, and captured 1 edge later.
// Backpressure: none. The slave never inserts wait states and every access completes in one cycle.
//
// Ports:
//   clk, reset_n          system clock, async active-low reset
//   address[2:0]          word address: 0 DATA, 1 DIR, 2 IRQMASK, 3 EDGECAP, 4 OUTSET, 5 OUTCLR
//   chipselect, write_n   write strobe is chipselect & ~write_n
//   writedata[31:0]       bits above WIDTH are dropped
//   readdata[31:0]        combinational read mux, zero-extended above WIDTH
//   in_port[WIDTH-1:0]    asynchronous pins
//   out_port[WIDTH-1:0]   data_out register
//   oe[WIDTH-1:0]         direction register, 1 = drive pin
//   irq                   |(edgecap & irqmask)
module avalon_pio_ext #(
  parameter int unsigned            WIDTH       = 9,
  parameter logic [WIDTH-1:0]       RESET_VALUE = '0,
  parameter logic [WIDTH-1:0]       RESET_DIR   = '0,
  parameter int unsigned            EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] cap_clr;
  logic [WIDTH-1:0] wdat;
  logic [WIDTH-1:0] rsel;
  logic             wr;

  // Upper writedata bits are deliberately dropped; fold them into a sink so they
  // do not show up as dangling inputs.
  logic unused_wdat;
  assign unused_wdat = ^writedata;

  assign wr   = chipselect & ~write_n;
  assign wdat = writedata[WIDTH-1:0];

  // Output and control registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= RESET_VALUE;
      dir      <= RESET_DIR;
      irqmask  <= '0;
    end else if (wr) begin
      case (address)
        ADDR_DATA:    data_out <= wdat;
        ADDR_DIR:     dir      <= wdat;
        ADDR_IRQMASK: irqmask  <= wdat;
        ADDR_OUTSET:  data_out <= data_out | wdat;
        ADDR_OUTCLR:  data_out <= data_out & ~wdat;
        default: ;
      endcase
    end
  end

  // Two-flop synchroniser plus one history flop for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  generate
    if (EDGE_TYPE == 1) begin : g_fall
      assign edge_det = ~sync2 & prev;
    end else if (EDGE_TYPE == 2) begin : g_any
      assign edge_det = sync2 ^ prev;
    end else begin : g_rise
      assign edge_det = sync2 & ~prev;
    end
  endgenerate

  assign cap_clr = (wr && (address == ADDR_EDGECAP)) ? wdat : '0;

  // A new edge ORed in after the clear, so a coincident edge keeps its bit set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edgecap <= '0;
    end else begin
      edgecap <= (edgecap & ~cap_clr) | edge_det;
    end
  end

  always_comb begin
    rsel = '0;
    case (address)
      ADDR_DATA:    rsel = (dir & data_out) | (~dir & sync2);
      ADDR_DIR:     rsel = dir;
      ADDR_IRQMASK: rsel = irqmask;
      ADDR_EDGECAP: rsel = edgecap;
      default:      rsel = '0;
    endcase
  end

  assign readdata = 32'(rsel);
  assign out_port = data_out;
  assign oe       = dir;
  assign irq      = |(edgecap & irqmask);

endmodule

// File: tb/tb_avalon_pio_ext.sv
module tb_avalon_pio_ext;

  localparam int unsigned W = 9;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [2:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [W-1:0]  in_port;
  logic [31:0]   rd0, rd2;
  logic [W-1:0]  out0, out2, oe0, oe2;
  logic          irq0, irq2;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  // Rising-edge capture instance.
  avalon_pio_ext #(.WIDTH(W), .RESET_VALUE(9'h1A5), .RESET_DIR(9'h1FF), .EDGE_TYPE(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd0), .in_port(in_port),
    .out_port(out0), .oe(oe0), .irq(irq0)
  );

  // Any-edge capture instance sharing the same bus and pins.
  avalon_pio_ext #(.WIDTH(W), .RESET_VALUE(9'h1A5), .RESET_DIR(9'h1FF), .EDGE_TYPE(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd2), .in_port(in_port),
    .out_port(out2), .oe(oe2), .irq(irq2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d0, output logic [31:0] d2);
    address = a;
    #1;
    d0 = rd0;
    d2 = rd2;
  endtask

  task automatic test_reset();
    logic [31:0] r0, r2;
    logic [31:0] exp_rd [4];
    exp_rd[0] = 32'h1A5; exp_rd[1] = 32'h1FF; exp_rd[2] = 32'h0; exp_rd[3] = 32'h0;
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = '0;
    writedata = '0; in_port = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    tick();
    checks++; if (out0 !== 9'h1A5) begin fails++; $display("FAIL reset_out_port got %h want 1a5", out0); end
    checks++; if (oe0 !== 9'h1FF) begin fails++; $display("FAIL reset_oe got %h want 1ff", oe0); end
    checks++; if (irq0 !== 1'b0 || irq2 !== 1'b0) begin fails++; $display("FAIL reset_irq got %b/%b want 0/0", irq0, irq2); end
    for (int a = 0; a < 4; a++) begin
      bus_read(3'(a), r0, r2);
      checks++;
      if (r0 !== exp_rd[a]) begin fails++; $display("FAIL reset_read addr %0d got %h want %h", a, r0, exp_rd[a]); end
    end
  endtask

  task automatic test_output();
    logic [31:0] r0, r2;
    bus_write(3'd0, 32'h0F0);
    checks++; if (out0 !== 9'h0F0) begin fails++; $display("FAIL data_write got %h want 0f0", out0); end
    bus_write(3'd4, 32'h003);
    checks++; if (out0 !== 9'h0F3) begin fails++; $display("FAIL outset got %h want 0f3", out0); end
    bus_write(3'd5, 32'h030);
    checks++; if (out0 !== 9'h0C3) begin fails++; $display("FAIL outclr got %h want 0c3", out0); end
    for (int a = 4; a < 8; a++) begin
      bus_read(3'(a), r0, r2);
      checks++;
      if (r0 !== 32'h0) begin fails++; $display("FAIL read_zero addr %0d got %h want 0", a, r0); end
    end
    bus_write(3'd6, 32'h1FF);
    checks++; if (out0 !== 9'h0C3 || oe0 !== 9'h1FF) begin fails++; $display("FAIL write_addr6_ignored out %h oe %h want 0c3 1ff", out0, oe0); end
    bus_read(3'd0, r0, r2);
    checks++; if (r0 !== 32'h0C3) begin fails++; $display("FAIL data_readback got %h want 0c3", r0); end
  endtask

  task automatic test_input();
    logic [31:0] r0, r2;
    // Upper writedata bits set, low WIDTH bits zero: DIR must become 0.
    bus_write(3'd1, 32'hFFFF_FE00);
    bus_read(3'd1, r0, r2);
    checks++; if (r0 !== 32'h0) begin fails++; $display("FAIL dir_upper_bits got %h want 0", r0); end
    in_port = 9'h155;
    tick();
    bus_read(3'd0, r0, r2);
    checks++; if (r0 !== 32'h0) begin fails++; $display("FAIL input_early got %h want 0", r0); end
    tick();
    bus_read(3'd0, r0, r2);
    checks++; if (r0 !== 32'h155) begin fails++; $display("FAIL input_sync got %h want 155", r0); end
    tick();
    bus_read(3'd3, r0, r2);
    checks++; if (r0 !== 32'h155 || r2 !== 32'h155) begin fails++; $display("FAIL input_edgecap got %h/%h want 155/155", r0, r2); end
    // Partial clear leaves bit 2 pending; it is masked so no irq.
    bus_write(3'd3, 32'h151);
    bus_read(3'd3, r0, r2);
    checks++; if (r0 !== 32'h004 || r2 !== 32'h004) begin fails++; $display("FAIL partial_clear got %h/%h want 004/004", r0, r2); end
    bus_write(3'd2, 32'h001);
    checks++; if (irq0 !== 1'b0) begin fails++; $display("FAIL masked_irq got %b want 0", irq0); end
  endtask

  task automatic test_edge_irq();
    logic [31:0] r0, r2;
    in_port = 9'h154;
    repeat (3) tick();
    bus_read(3'd3, r0, r2);
    checks++; if (r0 !== 32'h004) begin fails++; $display("FAIL falling_ignored_rise got %h want 004", r0); end
    checks++; if (r2 !== 32'h005 || irq2 !== 1'b1) begin fails++; $display("FAIL falling_any got %h irq %b want 005 1", r2, irq2); end
    bus_write(3'd3, 32'h001);
    in_port = 9'h155;
    tick(); tick();
    bus_read(3'd3, r0, r2);
    checks++; if (r0 !== 32'h004 || irq0 !== 1'b0) begin fails++; $display("FAIL rise_k1 got %h irq %b want 004 0", r0, irq0); end
    tick();
    bus_read(3'd3, r0, r2);
    checks++; if (r0 !== 32'h005 || irq0 !== 1'b1) begin fails++; $display("FAIL rise_k2 got %h irq %b want 005 1", r0, irq0); end
    checks++; if (r2 !== 32'h005) begin fails++; $display("FAIL rise_any got %h want 005", r2); end
    bus_write(3'd3, 32'h001);
    checks++; if (irq0 !== 1'b0) begin fails++; $display("FAIL irq_clear got %b want 0", irq0); end
    in_port = 9'h154;
    repeat (3) tick();
    bus_read(3'd3, r0, r2);
    checks++; if (r0 !== 32'h004 || irq0 !== 1'b0) begin fails++; $display("FAIL fall_after_clear got %h irq %b want 004 0", r0, irq0); end
  endtask

  task automatic test_set_wins();
    logic [31:0] r0, r2;
    in_port = 9'h155;
    repeat (3) tick();
    in_port = 9'h154;
    repeat (3) tick();
    bus_read(3'd3, r0, r2);
    checks++; if (r0 !== 32'h005 || irq0 !== 1'b1) begin fails++; $display("FAIL pre_collision got %h irq %b want 005 1", r0, irq0); end
    in_port = 9'h155;
    tick(); tick();
    // Clear lands on the same edge that captures the new rising edge.
    bus_write(3'd3, 32'h1FF);
    bus_read(3'd3, r0, r2);
    checks++; if (r0 !== 32'h001 || irq0 !== 1'b1) begin fails++; $display("FAIL set_wins got %h irq %b want 001 1", r0, irq0); end
    checks++; if (r2 !== 32'h001 || irq2 !== 1'b1) begin fails++; $display("FAIL set_wins_any got %h irq %b want 001 1", r2, irq2); end
    bus_write(3'd2, 32'h000);
    checks++; if (irq0 !== 1'b0) begin fails++; $display("FAIL mask_off got %b want 0", irq0); end
    bus_write(3'd2, 32'h001);
    checks++; if (irq0 !== 1'b1) begin fails++; $display("FAIL mask_on got %b want 1", irq0); end
  endtask

  task automatic test_async_reset();
    logic [31:0] r0, r2;
    bus_write(3'd0, 32'h1FF);
    bus_write(3'd1, 32'h1FF);
    checks++; if (out0 !== 9'h1FF || irq0 !== 1'b1) begin fails++; $display("FAIL pre_reset out %h irq %b want 1ff 1", out0, irq0); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (out0 !== 9'h1A5 || irq0 !== 1'b0 || irq2 !== 1'b0) begin fails++; $display("FAIL async_reset out %h irq %b/%b want 1a5 0/0", out0, irq0, irq2); end
    bus_read(3'd3, r0, r2);
    checks++; if (r0 !== 32'h0) begin fails++; $display("FAIL async_reset_edgecap got %h want 0", r0); end
    tick();
    #1 reset_n = 1'b1;
    // in_port is still 0x155 with synchroniser cleared: a rising edge gets captured.
    repeat (3) tick();
    bus_read(3'd3, r0, r2);
    checks++; if (r0 !== 32'h155) begin fails++; $display("FAIL release_capture got %h want 155", r0); end
  endtask

  initial begin
    test_reset();
    test_output();
    test_input();
    test_edge_irq();
    test_set_wins();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
